// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//
// Game sequencer for the pong datapath. It decides when the ball may move,
// serves the ball from the centre, detects misses at either wall, keeps
// score and ends the game at WIN_SCORE. All delays are counted in frames
// using the one-cycle frame_tick from the video timing block.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   frame_tick   one-cycle pulse, once per frame
//   start_btn    start button (synchronised level)
//   pause        level; freezes play and all delays while high
//   ball_x_pos   current ball x position
//   ball_y_pos   current ball y position (status only, not decoded)
//   ball_enable  ball may advance this frame
//   ball_load    one-cycle pulse: ball loads serve_x/serve_y/serve_dir
//   serve_x      serve x position (constant SERVE_X)
//   serve_y      serve y position (constant SERVE_Y)
//   serve_dir    1 = serve toward +x, 0 = toward -x
//   score_left   left player score (saturates at 15)
//   score_right  right player score (saturates at 15)
//   game_over    high while in GAME_OVER
//   state_dbg    IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4
module pong_game_ctrl #(
  parameter logic [9:0] LEFT_MISS_X  = 10'd8,
  parameter logic [9:0] RIGHT_MISS_X = 10'd632,
  parameter logic [9:0] SERVE_X      = 10'd320,
  parameter logic [9:0] SERVE_Y      = 10'd240,
  parameter logic [7:0] SERVE_DELAY  = 8'd60,
  parameter logic [7:0] POINT_DELAY  = 8'd90,
  parameter logic [3:0] WIN_SCORE    = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  output logic       ball_enable,
  output logic       ball_load,
  output logic [9:0] serve_x,
  output logic [9:0] serve_y,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_POINT      = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       start_q;
  logic       start_armed;
  logic       start_press;
  logic       frame_go;
  logic [3:0] score_left_inc;
  logic [3:0] score_right_inc;
  logic       unused_y;

  // start_armed only sets once the button has been seen low after reset,
  // so a button held through reset release never counts as a press.
  assign start_press = start_btn & ~start_q & start_armed;

  // Frames only advance the game while not paused.
  assign frame_go = frame_tick & ~pause;

  assign score_left_inc  = (score_left  == 4'd15) ? 4'd15 : score_left  + 4'd1;
  assign score_right_inc = (score_right == 4'd15) ? 4'd15 : score_right + 4'd1;

  assign serve_x   = SERVE_X;
  assign serve_y   = SERVE_Y;
  assign state_dbg = state;

  // Ball y is carried on the port for status only.
  assign unused_y = ^ball_y_pos;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      ball_enable <= 1'b0;
      ball_load   <= 1'b0;
      serve_dir   <= 1'b1;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
    end else begin
      start_q   <= start_btn;
      if (!start_btn) start_armed <= 1'b1;
      ball_load <= 1'b0;

      case (state)
        S_IDLE: begin
          ball_enable <= 1'b0;
          game_over   <= 1'b0;
          if (start_press) begin
            state     <= S_SERVE_WAIT;
            cnt       <= SERVE_DELAY;
            serve_dir <= 1'b1;
          end
        end

        S_SERVE_WAIT: begin
          ball_enable <= 1'b0;
          // A count of 0 or 1 both release on this frame, so a zero
          // delay behaves as one frame.
          if (frame_go) begin
            if (cnt <= 8'd1) begin
              state     <= S_PLAY;
              ball_load <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        S_PLAY: begin
          // Registered, so enable rises the cycle after the load pulse.
          ball_enable <= ~pause;
          if (frame_go) begin
            // Left miss wins if both conditions were ever true together.
            if (ball_x_pos <= LEFT_MISS_X) begin
              score_right <= score_right_inc;
              serve_dir   <= 1'b0;
              ball_enable <= 1'b0;
              if (score_right_inc == WIN_SCORE) begin
                state     <= S_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state <= S_POINT;
                cnt   <= POINT_DELAY;
              end
            end else if (ball_x_pos >= RIGHT_MISS_X) begin
              score_left  <= score_left_inc;
              serve_dir   <= 1'b1;
              ball_enable <= 1'b0;
              if (score_left_inc == WIN_SCORE) begin
                state     <= S_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state <= S_POINT;
                cnt   <= POINT_DELAY;
              end
            end
          end
        end

        S_POINT: begin
          ball_enable <= 1'b0;
          if (frame_go) begin
            if (cnt <= 8'd1) begin
              state <= S_SERVE_WAIT;
              cnt   <= SERVE_DELAY;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        S_GAME_OVER: begin
          ball_enable <= 1'b0;
          if (start_press) begin
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_dir   <= 1'b1;
            game_over   <= 1'b0;
            state       <= S_SERVE_WAIT;
            cnt         <= SERVE_DELAY;
          end else begin
            game_over <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          ball_enable <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed sequence with randomized ball
// positions, checked against a score/state model kept in plain integers.
module tb_pong_game_ctrl;

  localparam int LEFT_MISS    = 8;
  localparam int RIGHT_MISS   = 632;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 90;
  localparam int WIN          = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic       pause;
  logic [9:0] ball_x_pos;
  logic [9:0] ball_y_pos;
  logic       ball_enable;
  logic       ball_load;
  logic [9:0] serve_x;
  logic [9:0] serve_y;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_loads  = 0;

  // Reference model: scores, serve direction and state (spec encoding).
  int m_left, m_right, m_dir, m_state;
  logic [7:0] exp_q[$];

  pong_game_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .pause       (pause),
    .ball_x_pos  (ball_x_pos),
    .ball_y_pos  (ball_y_pos),
    .ball_enable (ball_enable),
    .ball_load   (ball_load),
    .serve_x     (serve_x),
    .serve_y     (serve_y),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .state_dbg   (state_dbg)
  );

  // Clock block
  always #5 clk = ~clk;

  always @(negedge clk) if (ball_load === 1'b1) n_loads++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
  endtask

  // Spend 'frames' frames in the current state; the last one leaves it.
  task automatic wait_frames(input int frames, input string tag);
    for (int i = 0; i < frames - 1; i++) tick();
    chk({tag, " hold"}, state_dbg, m_state);
    tick();
  endtask

  task automatic finish_point();
    wait_frames(POINT_FRAMES, "point");
    m_state = 1;
    chk("point->serve", state_dbg, m_state);
  endtask

  task automatic finish_serve(input int frames);
    int loads0;
    loads0 = n_loads;
    wait_frames(frames, "serve");
    m_state = 2;
    chk("serve->play", state_dbg, m_state);
    chk("load pulse", ball_load, 1);
    chk("enable with load", ball_enable, 0);
    chk("serve_dir at load", serve_dir, m_dir);
    @(negedge clk);
    chk("load cleared", ball_load, 0);
    chk("enable after load", ball_enable, 1);
    chk("load count", n_loads - loads0, 1);
  endtask

  // One PLAY frame with the ball at x; the model decides the outcome.
  task automatic play_frame(input int x);
    int kind;
    logic [7:0] exp_sc;
    kind = (x <= LEFT_MISS) ? 1 : ((x >= RIGHT_MISS) ? 2 : 0);
    ball_x_pos = 10'(x);
    tick();
    if (kind == 1) begin
      m_right = (m_right < 15) ? m_right + 1 : 15;
      m_dir   = 0;
      m_state = (m_right == WIN) ? 4 : 3;
    end else if (kind == 2) begin
      m_left  = (m_left < 15) ? m_left + 1 : 15;
      m_dir   = 1;
      m_state = (m_left == WIN) ? 4 : 3;
    end
    exp_q.push_back({m_left[3:0], m_right[3:0]});
    exp_sc = exp_q.pop_front();
    chk("scores", {score_left, score_right}, exp_sc);
    chk("play state", state_dbg, m_state);
    chk("serve_dir", serve_dir, m_dir);
    chk("enable after frame", ball_enable, (kind == 0));
    chk("game_over", game_over, (m_state == 4));
    ball_x_pos = 10'd320;
  endtask

  initial begin
    int loads0;
    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; pause = 1'b0;
    ball_x_pos = 10'd320; ball_y_pos = 10'd240;
    m_left = 0; m_right = 0; m_dir = 1; m_state = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst state", state_dbg, 0);
    chk("rst enable", ball_enable, 0);
    chk("rst load", ball_load, 0);
    chk("rst serve_dir", serve_dir, 1);
    chk("rst serve_x", serve_x, 320);
    chk("rst serve_y", serve_y, 240);
    chk("rst score_left", score_left, 0);
    chk("rst score_right", score_right, 0);
    chk("rst game_over", game_over, 0);

    // First serve
    press();
    m_state = 1; m_dir = 1;
    chk("press idle", state_dbg, m_state);
    finish_serve(SERVE_FRAMES);

    // Start press during play is ignored
    press();
    chk("press in play", state_dbg, 2);
    repeat (3) play_frame($urandom_range(LEFT_MISS + 1, RIGHT_MISS - 1));

    // Left miss, then point and serve delays
    play_frame($urandom_range(0, LEFT_MISS));
    finish_point();
    finish_serve(SERVE_FRAMES);

    // Right misses until the left player wins
    while (m_state != 4) begin
      repeat ($urandom_range(0, 2)) play_frame($urandom_range(LEFT_MISS + 1, RIGHT_MISS - 1));
      play_frame($urandom_range(RIGHT_MISS, 1023));
      if (m_state == 3) begin
        finish_point();
        finish_serve(SERVE_FRAMES);
      end
    end

    // GAME_OVER holds: no serve, no scoring, pause ignored
    loads0 = n_loads;
    ball_x_pos = 10'd0;
    repeat (5) tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    ball_x_pos = 10'd320;
    @(negedge clk);
    chk("over state", state_dbg, 4);
    chk("over flag", game_over, 1);
    chk("over enable", ball_enable, 0);
    chk("over scores", {score_left, score_right}, {4'd9, 4'd1});
    chk("over no load", n_loads - loads0, 0);

    press();
    m_left = 0; m_right = 0; m_dir = 1; m_state = 1;
    chk("restart state", state_dbg, m_state);
    chk("restart scores", {score_left, score_right}, 8'd0);
    chk("restart flag", game_over, 0);
    chk("restart dir", serve_dir, 1);

    // Pause freezes the serve delay
    repeat (10) tick();
    pause = 1'b1;
    repeat (30) tick();
    chk("paused serve state", state_dbg, 1);
    chk("paused serve enable", ball_enable, 0);
    pause = 1'b0;
    finish_serve(SERVE_FRAMES - 10);

    // Pause in play: enable low, no miss checks
    pause = 1'b1;
    repeat (2) @(negedge clk);
    chk("paused play enable", ball_enable, 0);
    ball_x_pos = 10'd0;
    repeat (30) tick();
    chk("paused play scores", {score_left, score_right}, 8'd0);
    chk("paused play state", state_dbg, 2);
    ball_x_pos = 10'd320;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("unpaused enable", ball_enable, 1);

    // Build a 3-2 score, ending in POINT
    play_frame($urandom_range(0, LEFT_MISS));
    finish_point(); finish_serve(SERVE_FRAMES);
    play_frame($urandom_range(RIGHT_MISS, 1023));
    finish_point(); finish_serve(SERVE_FRAMES);
    play_frame($urandom_range(RIGHT_MISS, 1023));
    finish_point(); finish_serve(SERVE_FRAMES);
    play_frame($urandom_range(0, LEFT_MISS));
    finish_point(); finish_serve(SERVE_FRAMES);
    play_frame($urandom_range(RIGHT_MISS, 1023));
    chk("3-2 point", state_dbg, 3);

    // Asynchronous reset mid-point
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async rst state", state_dbg, 0);
    chk("async rst scores", {score_left, score_right}, 8'd0);
    chk("async rst enable", ball_enable, 0);
    chk("async rst load", ball_load, 0);
    chk("async rst dir", serve_dir, 1);

    // Start held through reset release is not a press
    start_btn = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("held start", state_dbg, 0);
    start_btn = 1'b0;
    @(negedge clk);
    press();
    chk("press after release", state_dbg, 1);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
